// File: rtl/ota_cal_pkg.sv
// Shared definitions for the OTA offset-calibration controller.
//   cal_state_e : controller FSM states
//   CntW        : phase counter width, wide enough for any 1..255 cycle phase
//   TrimWMax    : widest supported trim code
//   mid_code()  : mid-scale trim code for a given trim width
package ota_cal_pkg;

  localparam int unsigned CntW     = $clog2(256);
  localparam int unsigned TrimWMax = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStartup,
    StBiasSettle,
    StCalSettle,
    StCalSample,
    StDone
  } cal_state_e;

  function automatic logic [TrimWMax-1:0] mid_code(input int unsigned trim_w);
    return TrimWMax'(1) << (trim_w - 1);
  endfunction

endpackage

// File: rtl/ota_cal_sar_ch.sv
// Per-channel successive-approximation trim register.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset, loads mid-scale
//   clear_i     : abort, loads mid-scale
//   init_i      : calibration entry, clears the code and sets the MSB
//   sample_i    : resolve the current bit from cmp_i and arm the next lower bit
//   bit_idx_i   : bit currently under test
//   cmp_i       : comparator, 1 = trimmed offset still positive
//   trim_o      : trim code
module ota_cal_sar_ch
  import ota_cal_pkg::*;
#(
  parameter int unsigned TRIM_W = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              init_i,
  input  logic              sample_i,
  input  logic [IDX_W-1:0]  bit_idx_i,
  input  logic              cmp_i,
  output logic [TRIM_W-1:0] trim_o
);

  localparam logic [TRIM_W-1:0] Mid = TRIM_W'(mid_code(TRIM_W));

  logic [TRIM_W-1:0] trim_d, trim_q;

  always_comb begin
    trim_d = trim_q;
    if (clear_i) begin
      trim_d = Mid;
    end else if (init_i) begin
      // All-zero code with the MSB set: numerically the same as mid-scale.
      trim_d = Mid;
    end else if (sample_i) begin
      if (cmp_i) begin
        trim_d[bit_idx_i] = 1'b0;
      end
      // Next bit is armed on the same edge that resolves this one.
      if (bit_idx_i != '0) begin
        trim_d[bit_idx_i - IDX_W'(1)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trim_q <= Mid;
    end else begin
      trim_q <= trim_d;
    end
  end

  assign trim_o = trim_q;

endmodule

// File: rtl/ota_cal_ctrl.sv
// OTA bias start-up and offset-trim calibration controller.
//   clk_i          : clock
//   rst_i          : synchronous active-high reset
//   start_i        : one-cycle run request, honoured only in idle
//   skip_startup_i : with start_i, skip bias start-up if the bias is already on
//   abort_i        : terminate any run, return to idle with bias off, trims mid-scale
//   cmp_in_i       : per-channel offset comparator, 1 = offset positive
//   startup_en_o   : bias start-up pull switches
//   bias_en_o      : cascode bias enable, held after a completed run
//   cal_mode_o     : shorts OTA inputs during offset measurement
//   trim_o         : trim codes, channel c at [c*TRIM_W +: TRIM_W]
//   busy_o         : high outside idle
//   done_o         : one-cycle completion pulse
module ota_cal_ctrl
  import ota_cal_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned TRIM_W      = 4,
  parameter int unsigned STARTUP_CYC = 4,
  parameter int unsigned SETTLE_CYC  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  skip_startup_i,
  input  logic                  abort_i,
  input  logic [NCH-1:0]        cmp_in_i,
  output logic                  startup_en_o,
  output logic                  bias_en_o,
  output logic                  cal_mode_o,
  output logic [NCH*TRIM_W-1:0] trim_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned IdxW = $clog2(TRIM_W);

  localparam logic [CntW-1:0] StartupLoad = CntW'(STARTUP_CYC - 1);
  localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYC - 1);
  localparam logic [IdxW-1:0] TopIdx      = IdxW'(TRIM_W - 1);

  cal_state_e      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic [IdxW-1:0] idx_d, idx_q;
  logic            bias_d, bias_q;
  logic            sar_clear, sar_init, sar_sample;

  // Counters load phase-length minus one on entry and count down to zero,
  // so they never wrap inside a phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bias_d     = bias_q;
    sar_clear  = 1'b0;
    sar_init   = 1'b0;
    sar_sample = 1'b0;

    if (abort_i) begin
      state_d   = StIdle;
      cnt_d     = '0;
      bias_d    = 1'b0;
      sar_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (skip_startup_i && bias_q) begin
              state_d  = StCalSettle;
              cnt_d    = SettleLoad;
              idx_d    = TopIdx;
              sar_init = 1'b1;
            end else begin
              state_d = StStartup;
              cnt_d   = StartupLoad;
              bias_d  = 1'b0;
            end
          end
        end
        StStartup: begin
          if (cnt_q == '0) begin
            state_d = StBiasSettle;
            cnt_d   = SettleLoad;
            bias_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StBiasSettle: begin
          if (cnt_q == '0) begin
            state_d  = StCalSettle;
            cnt_d    = SettleLoad;
            idx_d    = TopIdx;
            sar_init = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StCalSettle: begin
          if (cnt_q == '0) begin
            state_d = StCalSample;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StCalSample: begin
          sar_sample = 1'b1;
          if (idx_q == '0) begin
            state_d = StDone;
          end else begin
            state_d = StCalSettle;
            cnt_d   = SettleLoad;
            idx_d   = idx_q - IdxW'(1);
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      bias_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bias_q  <= bias_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ota_cal_sar_ch #(
      .TRIM_W (TRIM_W),
      .IDX_W  (IdxW)
    ) u_sar_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (sar_clear),
      .init_i    (sar_init),
      .sample_i  (sar_sample),
      .bit_idx_i (idx_q),
      .cmp_i     (cmp_in_i[c]),
      .trim_o    (trim_o[c*TRIM_W +: TRIM_W])
    );
  end

  assign startup_en_o = (state_q == StStartup);
  assign bias_en_o    = bias_q;
  assign cal_mode_o   = (state_q == StCalSettle) || (state_q == StCalSample);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);

endmodule

// File: tb/tb_ota_cal_ctrl.sv
// Self-checking bench for ota_cal_ctrl with NCH=2, TRIM_W=4, STARTUP_CYC=4, SETTLE_CYC=3.
module tb_ota_cal_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       skip;
  logic       abort;
  logic [1:0] cmp_in;
  logic       startup_en;
  logic       bias_en;
  logic       cal_mode;
  logic [7:0] trim;
  logic       busy;
  logic       done;

  int mode;
  int n_chk;
  int n_fail;

  ota_cal_ctrl #(
    .NCH         (2),
    .TRIM_W      (4),
    .STARTUP_CYC (4),
    .SETTLE_CYC  (3)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .skip_startup_i (skip),
    .abort_i        (abort),
    .cmp_in_i       (cmp_in),
    .startup_en_o   (startup_en),
    .bias_en_o      (bias_en),
    .cal_mode_o     (cal_mode),
    .trim_o         (trim),
    .busy_o         (busy),
    .done_o         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: ch c reports 1 while its trimmed offset is above a threshold.
  always_comb begin
    cmp_in = 2'b00;
    case (mode)
      0:       cmp_in = {1'b0, trim[3:0] > 4'd5};
      1:       cmp_in = 2'b11;
      default: cmp_in = {trim[7:4] > 4'd2, trim[3:0] > 4'd9};
    endcase
  end

  typedef struct {
    logic skip;
    int   mode;
    int   lat;
    int   t0;
    int   t1;
    int   su;
    int   fb;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int n, su, fb, cal;
    bit got;
    @(negedge clk);
    start = 1'b1;
    skip  = v.skip;
    mode  = v.mode;
    @(negedge clk);
    start = 1'b0;
    skip  = 1'b0;
    n = 1; su = 0; fb = 0; cal = 0; got = 0;
    while (n <= 100) begin
      if (startup_en) su++;
      if (bias_en && fb == 0) fb = n;
      if (cal_mode) cal++;
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d latency", idx), got ? n : -1, v.lat);
    chk($sformatf("v%0d trim0", idx), int'(trim[3:0]), v.t0);
    chk($sformatf("v%0d trim1", idx), int'(trim[7:4]), v.t1);
    chk($sformatf("v%0d startup_cycles", idx), su, v.su);
    chk($sformatf("v%0d first_bias_cycle", idx), fb, v.fb);
    chk($sformatf("v%0d cal_mode_cycles", idx), cal, 16);
    @(negedge clk);
    chk($sformatf("v%0d done_width", idx), int'(done), 0);
    chk($sformatf("v%0d idle_after", idx), int'(busy), 0);
    chk($sformatf("v%0d bias_held", idx), int'(bias_en), 1);
    chk($sformatf("v%0d trim_held", idx), int'(trim), (v.t1 << 4) | v.t0);
  endtask

  initial begin
    bit seen_done;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; skip = 1'b0; abort = 1'b0; mode = 0;

    // Skip requested with bias off still runs start-up; then skip with bias on.
    vecs[0] = '{skip: 1'b1, mode: 0, lat: 24, t0: 5,  t1: 15, su: 4, fb: 5};
    vecs[1] = '{skip: 1'b1, mode: 0, lat: 17, t0: 5,  t1: 15, su: 0, fb: 1};
    vecs[2] = '{skip: 1'b0, mode: 1, lat: 24, t0: 0,  t1: 0,  su: 4, fb: 5};
    vecs[3] = '{skip: 1'b1, mode: 2, lat: 17, t0: 9,  t1: 2,  su: 0, fb: 1};

    @(negedge clk);
    @(negedge clk);
    chk("rst startup_en", int'(startup_en), 0);
    chk("rst bias_en", int'(bias_en), 0);
    chk("rst cal_mode", int'(cal_mode), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst trim", int'(trim), 8'h88);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) apply(vecs[i], i);

    // Reset in the middle of start-up, alongside start and abort.
    @(negedge clk);
    start = 1'b1; mode = 0;
    @(negedge clk);
    start = 1'b0;
    chk("mid startup_en", int'(startup_en), 1);
    chk("mid bias_off", int'(bias_en), 0);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("midrst startup_en", int'(startup_en), 0);
    chk("midrst bias_en", int'(bias_en), 0);
    chk("midrst cal_mode", int'(cal_mode), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst trim", int'(trim), 8'h88);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("post rst idle", int'(busy), 0);

    // Abort in the sample cycle of bit 2 (cycle 15 after start).
    start = 1'b1; mode = 0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 15; n++) @(negedge clk);
    chk("abort pre cal_mode", int'(cal_mode), 1);
    chk("abort pre trim", int'(trim), 8'hC4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort bias_en", int'(bias_en), 0);
    chk("abort cal_mode", int'(cal_mode), 0);
    chk("abort startup_en", int'(startup_en), 0);
    chk("abort trim", int'(trim), 8'h88);
    seen_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (done || busy) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("abort no done", int'(seen_done), 0);

    // Abort and start together in idle: start is discarded.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort+start busy", int'(busy), 0);
    chk("abort+start startup_en", int'(startup_en), 0);
    @(negedge clk);
    chk("abort+start still idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ota_cal_ctrl.md
OTA_CAL_CTRL -- requirements
Module: ota_cal_ctrl

Interface
REQ-001 Parameter NCH, default 2: number of OTA channels calibrated in parallel, 1..16.
REQ-002 Parameter TRIM_W, default 4: offset-trim code width per channel, 2..8.
REQ-003 Parameter STARTUP_CYC, default 4: cycles the bias start-up switches are held on, 1..255.
REQ-004 Parameter SETTLE_CYC, default 3: analog settle cycles per step, 1..255.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port start, input, 1: single-cycle request to begin a calibration run.
REQ-008 Port skip_startup, input, 1: sampled with start; 1 means skip the bias start-up phase.
REQ-009 Port abort, input, 1: terminates any run.
REQ-010 Port cmp_in, input, NCH: per-channel offset comparator; 1 means the trimmed offset is positive.
REQ-011 Port startup_en, output, 1: drives the bias start-up pull switches.
REQ-012 Port bias_en, output, 1: enables the cascode bias network.
REQ-013 Port cal_mode, output, 1: shorts the OTA inputs for offset measurement.
REQ-014 Port trim, output, NCH*TRIM_W: trim codes; channel c occupies bits [c*TRIM_W +: TRIM_W].
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse marking run completion.

Function
REQ-017 The FSM SHALL have states IDLE, STARTUP, BIAS_SETTLE, CAL_SETTLE, CAL_SAMPLE and DONE.
REQ-018 In IDLE, start=1 SHALL move to STARTUP next cycle, or to CAL_SETTLE if skip_startup=1 and bias_en=1.
REQ-019 If skip_startup=1 while bias_en=0, the run SHALL proceed to STARTUP.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 STARTUP SHALL last exactly STARTUP_CYC cycles with startup_en=1 and bias_en=0.
REQ-022 BIAS_SETTLE SHALL last exactly SETTLE_CYC cycles with startup_en=0 and bias_en=1.
REQ-023 Entry to calibration SHALL set all trim codes to 0 and the bit index to TRIM_W-1.
REQ-024 cal_mode SHALL be 1 throughout CAL_SETTLE and CAL_SAMPLE and 0 otherwise.
REQ-025 On each CAL_SETTLE entry, the current bit of every channel's trim SHALL be set to 1; CAL_SETTLE SHALL last SETTLE_CYC cycles.
REQ-026 CAL_SAMPLE SHALL last 1 cycle; for each channel with cmp_in[c]=1, the current bit SHALL be cleared; a 0 keeps the bit.
REQ-027 After CAL_SAMPLE, the FSM SHALL go to CAL_SETTLE for the next lower bit, or to DONE after bit 0.
REQ-028 DONE SHALL last 1 cycle with done=1, then go to IDLE; trim and bias_en=1 SHALL be held afterwards.
REQ-029 Start-to-done latency SHALL be 1+STARTUP_CYC+SETTLE_CYC+TRIM_W*(SETTLE_CYC+1) cycles with start-up, or 1+TRIM_W*(SETTLE_CYC+1) with skip.
REQ-030 abort=1 in any state SHALL force IDLE next cycle: startup_en=0, bias_en=0, cal_mode=0, done=0, all trim=midcode (1<<(TRIM_W-1)).
REQ-031 When abort and start are both 1 in the same cycle, abort SHALL win and start SHALL be discarded.
REQ-032 Settle counters SHALL be ceil(log2(256)) bits wide and SHALL not wrap within a phase.

Reset
REQ-033 While rst=1, the block SHALL enter IDLE with startup_en=0, bias_en=0, cal_mode=0, busy=0, done=0 and all trim=midcode.
REQ-034 rst SHALL override abort and start, and SHALL take effect mid-run at the next edge.

Structure
REQ-035 Package ota_cal_pkg SHALL hold the state enum and the midcode and counter-width constants.
REQ-036 Sub-module ota_cal_sar_ch SHALL implement the per-channel SAR trim register, instantiated NCH times.

Verification (NCH=2, TRIM_W=4, STARTUP_CYC=4, SETTLE_CYC=3)
REQ-037 After reset, with ch0 cmp=(trim0>5) and ch1 cmp=0, a start -> done exactly 24 cycles later, with trim0=5 and trim1=15.
REQ-038 A second start with skip_startup=1 and bias_en=1 -> no startup_en pulse, and done 17 cycles after start.
REQ-039 cmp_in held 2'b11 -> both codes 0; startup_en high exactly 4 cycles, then bias_en high from the 5th cycle on.
REQ-040 abort asserted in CAL_SAMPLE of bit 2 -> next cycle IDLE, bias_en=0, trim=8/8, done never asserted.
REQ-041 abort and start in the same IDLE cycle -> stays IDLE, busy=0; rst asserted mid-STARTUP -> all outputs reach their reset values at the next edge.
